// File: rtl/ks_adder_pipe.sv
// ks_adder_pipe: pipelined Kogge-Stone adder/subtractor.
// S0 registers the generate/propagate terms. Carry-in is folded into the bit-0
// generate term. Each following stage evaluates LPS prefix levels. The last
// stage also forms sum, cout, ovf and zero.
//
// Handshake: a beat moves on a rising edge when its valid is high and the
// receiver's ready is high. advance = !out_valid | out_ready. in_ready equals
// advance, combinationally. On advance every stage (bubbles included) shifts
// one place. Otherwise every register, data and tag included, holds.
module ks_adder_pipe #(
    parameter int N     = 16,
    parameter int LPS   = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             cin,
    input  logic             sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int L  = $clog2(N);
    localparam int NS = (L + LPS - 1) / LPS;

    // Apply the prefix levels lo..hi (1-based) to a {G,P} vector pair.
    // Bits below the level distance pass through unchanged.
    function automatic logic [2*N-1:0] prefix_levels(
        input logic [N-1:0] gi,
        input logic [N-1:0] pi,
        input int           lo,
        input int           hi
    );
        logic [N-1:0] g, p, gn, pn;
        int           d;
        g = gi;
        p = pi;
        for (int s = 1; s <= L; s++) begin
            if (s >= lo && s <= hi) begin
                d  = 1 << (s - 1);
                gn = g;
                pn = p;
                for (int j = 0; j < N; j++) begin
                    if (j >= d) begin
                        gn[j] = g[j] | (p[j] & g[j-d]);
                        pn[j] = p[j] & p[j-d];
                    end
                end
                g = gn;
                p = pn;
            end
        end
        return {g, p};
    endfunction

    // Stage registers. Index k holds the state after k prefix stages.
    logic             r_v   [NS];
    logic [N-1:0]     r_g   [NS];
    logic [N-1:0]     r_p   [NS];
    logic [N-1:0]     r_po  [NS];
    logic             r_c0  [NS];
    logic [TAG_W-1:0] r_tag [NS];

    logic             r_out_valid;
    logic [N-1:0]     r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic [TAG_W-1:0] r_out_tag;

    logic             w_advance;
    logic [N-1:0]     w_bx;
    logic             w_c0;
    logic [N-1:0]     w_g0;
    logic [N-1:0]     w_p0;
    logic [N-1:0]     w_g0f;
    logic [N-1:0]     w_gn  [NS];
    logic [N-1:0]     w_pn  [NS];
    logic [N-1:0]     w_gl;
    logic [N-1:0]     w_carry;
    logic [N-1:0]     w_sum;
    logic             w_cout;
    logic             w_ovf;
    logic             w_zero;

    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;

    // Operand conditioning and bit-level generate/propagate.
    // Subtraction is A + ~B + 1. Carry-in becomes part of g0.
    always_comb begin
        w_bx  = sub ? ~b : b;
        w_c0  = sub | cin;
        w_g0  = a & w_bx;
        w_p0  = a ^ w_bx;
        w_g0f = w_g0;
        w_g0f[0] = w_g0[0] | (w_p0[0] & w_c0);
    end

    // Prefix stage k evaluates levels k*LPS+1 .. (k+1)*LPS.
    // The last stage may have fewer than LPS real levels.
    for (genvar k = 0; k < NS; k++) begin : g_stage
        assign {w_gn[k], w_pn[k]} = prefix_levels(r_g[k], r_p[k], k*LPS + 1, (k+1)*LPS);
    end

    // Sum and flags from the fully resolved group generates.
    always_comb begin
        w_gl    = w_gn[NS-1];
        w_carry = {w_gl[N-2:0], r_c0[NS-1]};
        w_sum   = r_po[NS-1] ^ w_carry;
        w_cout  = w_gl[N-1];
        w_ovf   = w_carry[N-1] ^ w_gl[N-1];
        w_zero  = ~|w_sum;
    end

    // Pipeline shift on advance. Reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NS; k++) begin
                r_v[k]   <= 1'b0;
                r_g[k]   <= '0;
                r_p[k]   <= '0;
                r_po[k]  <= '0;
                r_c0[k]  <= 1'b0;
                r_tag[k] <= '0;
            end
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_out_tag   <= '0;
        end else if (w_advance) begin
            r_v[0]   <= in_valid;
            r_g[0]   <= w_g0f;
            r_p[0]   <= w_p0;
            r_po[0]  <= w_p0;
            r_c0[0]  <= w_c0;
            r_tag[0] <= in_tag;
            for (int k = 1; k < NS; k++) begin
                r_v[k]   <= r_v[k-1];
                r_g[k]   <= w_gn[k-1];
                r_p[k]   <= w_pn[k-1];
                r_po[k]  <= r_po[k-1];
                r_c0[k]  <= r_c0[k-1];
                r_tag[k] <= r_tag[k-1];
            end
            r_out_valid <= r_v[NS-1];
            r_sum       <= w_sum;
            r_cout      <= w_cout;
            r_ovf       <= w_ovf;
            r_zero      <= w_zero;
            r_out_tag   <= r_tag[NS-1];
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Testbench for ks_adder_pipe.
// Instance u_dut16 uses N=16, LPS=2. Instance u_dut4 uses N=4, LPS=1.
module tb_ks_adder_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- DUT 16-bit ----------------
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
    logic [15:0] a, b, sum;
    logic [3:0]  in_tag, out_tag;

    ks_adder_pipe #(.N(16), .LPS(2), .TAG_W(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf), .zero(zero), .out_tag(out_tag)
    );

    // ---------------- DUT 4-bit ----------------
    logic       in_valid4, in_ready4, cin4, sub4, out_valid4, out_ready4, cout4, ovf4, zero4;
    logic [3:0] a4, b4, sum4, in_tag4, out_tag4;

    ks_adder_pipe #(.N(4), .LPS(1), .TAG_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .sub(sub4), .in_tag(in_tag4),
        .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4),
        .cout(cout4), .ovf(ovf4), .zero(zero4), .out_tag(out_tag4)
    );

    int total = 0;
    int bad   = 0;

    logic [22:0] exp_q[$];   // {tag, sum16, cout, ovf, zero}
    logic [10:0] exp_q4[$];  // {tag, sum4, cout, ovf, zero}
    bit          drv_done;

    // Reference model: plain wide-integer arithmetic, n-bit operands.
    // Returns {sum[15:0], cout, ovf, zero}.
    function automatic logic [18:0] model(input int n, input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mcin, input logic msub);
        logic [16:0] mask, lmask, bb, full, lo;
        logic        c0, co, cm;
        logic [15:0] s;
        mask  = (17'd1 << n) - 17'd1;
        lmask = (17'd1 << (n - 1)) - 17'd1;
        bb    = msub ? (~{1'b0, mb} & mask) : {1'b0, mb};
        c0    = msub ? 1'b1 : mcin;
        full  = {1'b0, ma} + bb + {16'd0, c0};
        s     = full[15:0] & mask[15:0];
        co    = full[n];
        lo    = ({1'b0, ma} & lmask) + (bb & lmask) + {16'd0, c0};
        cm    = lo[n-1];
        return {s, co, cm ^ co, (s == 16'd0)};
    endfunction

    // ---------------- scoreboard, 16-bit ----------------
    always @(negedge clk) begin : sb16
        logic [18:0] m;
        logic [22:0] e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb16_extra got tag=%h sum=%h, required no beat", out_tag, sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_tag, sum, cout, ovf, zero} !== e) begin
                        bad++;
                        $display("FAIL sb16_beat got=%h required=%h", {out_tag, sum, cout, ovf, zero}, e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                m = model(16, a, b, cin, sub);
                exp_q.push_back({in_tag, m});
            end
        end
    end

    // ---------------- scoreboard, 4-bit ----------------
    always @(negedge clk) begin : sb4
        logic [18:0] m;
        logic [10:0] e;
        if (rst_n) begin
            if (out_valid4 && out_ready4) begin
                total++;
                if (exp_q4.size() == 0) begin
                    bad++;
                    $display("FAIL sb4_extra got tag=%h sum=%h, required no beat", out_tag4, sum4);
                end else begin
                    e = exp_q4.pop_front();
                    if ({out_tag4, sum4, cout4, ovf4, zero4} !== e) begin
                        bad++;
                        $display("FAIL sb4_beat got=%h required=%h", {out_tag4, sum4, cout4, ovf4, zero4}, e);
                    end
                end
            end
            if (in_valid4 && in_ready4) begin
                m = model(4, {12'd0, a4}, {12'd0, b4}, cin4, sub4);
                exp_q4.push_back({in_tag4, m[6:3], m[2:0]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Present one beat and hold it until accepted. Returns at posedge+1.
    task automatic drive16(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                           input logic tsub, input logic [3:0] ttag);
        bit acc;
        acc = 0;
        a = ta; b = tb; cin = tcin; sub = tsub; in_tag = ttag; in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) acc = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL drive16_accept got no accept in 200 cycles, required accept tag=%h", ttag);
        end
    endtask

    task automatic drive4(input logic [3:0] ta, input logic [3:0] tb, input logic tcin,
                          input logic tsub, input logic [3:0] ttag);
        bit acc;
        acc = 0;
        a4 = ta; b4 = tb; cin4 = tcin; sub4 = tsub; in_tag4 = ttag; in_valid4 = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (in_ready4) acc = 1;
            @(posedge clk);
            #1;
        end
        in_valid4 = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL drive4_accept got no accept in 200 cycles, required accept tag=%h", ttag);
        end
    endtask

    // Wait, bounded, until every expected beat has been emitted.
    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_q4.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        total++;
        if (exp_q.size() != 0 || exp_q4.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d/%0d beats outstanding, required 0/0", exp_q.size(), exp_q4.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || out_valid4 !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got %b/%b, required 0/0", out_valid, out_valid4);
        end
        total++;
        if ({sum, cout, ovf, zero, out_tag} !== 23'd0) begin
            bad++;
            $display("FAIL reset_data got %h, required 0", {sum, cout, ovf, zero, out_tag});
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || in_ready4 !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got %b/%b, required 1/1", in_ready, in_ready4);
        end
    endtask

    task automatic test_vectors();
        int lat;
        out_ready = 1'b1;
        drive16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'h1);
        lat = 0;
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            @(negedge clk);
            if (out_valid) lat = n;
        end
        total++;
        if (lat != 3) begin
            bad++;
            $display("FAIL latency got %0d, required 3", lat);
        end
        total++;
        if ({out_tag, sum, cout, zero, ovf} !== {4'h1, 16'h0000, 1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL wrap_ffff got tag=%h sum=%h c=%b z=%b v=%b, required 1 0000 1 1 0",
                     out_tag, sum, cout, zero, ovf);
        end
        @(posedge clk);
        #1;
        drive16(16'h0005, 16'h0007, 1'b1, 1'b1, 4'h2);
        drive16(16'h0007, 16'h0005, 1'b0, 1'b1, 4'h3);
        drive16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'h4);
        drive16(16'h8000, 16'h0001, 1'b0, 1'b1, 4'h5);
        drive16(16'h1234, 16'h4321, 1'b1, 1'b0, 4'h6);
        drain(20);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive16(16'h1234, 16'h1111, 1'b0, 1'b0, 4'h1);
        drive16(16'h0100, 16'h0200, 1'b0, 1'b0, 4'h2);
        drive16(16'hF000, 16'h0F00, 1'b1, 1'b0, 4'h3);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if ({in_ready, out_valid, out_tag, sum} !== {1'b0, 1'b1, 4'h1, 16'h2345}) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d got rdy=%b vld=%b tag=%h sum=%h, required 0 1 1 2345",
                         i, in_ready, out_valid, out_tag, sum);
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_tag !== k[3:0]) begin
                bad++;
                $display("FAIL release_order got vld=%b tag=%h, required 1 %h", out_valid, out_tag, k[3:0]);
            end
        end
        drain(20);
    endtask

    task automatic test_reset_in_flight();
        out_ready = 1'b0;
        drive16(16'h00AA, 16'h0055, 1'b0, 1'b0, 4'h7);
        drive16(16'h0F0F, 16'h0101, 1'b0, 1'b1, 4'h8);
        @(posedge clk);
        #3 rst_n = 1'b0;
        exp_q.delete();
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_async got vld=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL reset_flush cyc=%0d got vld=%b rdy=%b, required 0 1", i, out_valid, in_ready);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random16();
        drv_done = 0;
        fork
            begin
                for (int i = 0; i < 150; i++)
                    drive16(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i));
                drv_done = 1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain(50);
    endtask

    task automatic test_exhaustive4();
        drv_done = 0;
        fork
            begin
                for (int i = 0; i < 1024; i++) begin
                    int v;
                    v = i;
                    drive4(v[3:0], v[7:4], v[8], v[9], v[3:0] ^ v[7:4]);
                end
                drv_done = 1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1 out_ready4 = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready4 = 1'b1;
        drain(50);
    endtask

    initial begin
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; in_tag = '0; out_ready = 1'b1;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0; in_tag4 = '0; out_ready4 = 1'b1;
        drv_done = 0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_in_flight();
        test_random16();
        test_exhaustive4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
